// File: rtl/x_buffer_if.sv
// Handshake/strobe bundle between the X buffer sequencer and its environment.
// Optional feature macro: XBUF_CTRL_STALL_CNT_EN adds the stall_cnt signal.
interface x_buffer_if #(
  parameter int unsigned ELEM_W = 3,
  parameter int unsigned PASS_W = 2
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              input_load_en;
  logic              X_shift;
  logic              w_valid;
  logic              mac_en;
  logic              mac_clr;
  logic [ELEM_W-1:0] elem_idx;
  logic [PASS_W-1:0] pass_idx;
  logic              col_done;
  logic              busy;
  logic              done;
`ifdef XBUF_CTRL_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  // Environment side: issues start, upstream bytes and coefficient availability.
  modport master (
`ifdef XBUF_CTRL_STALL_CNT_EN
    input  stall_cnt,
`endif
    output start, in_valid, w_valid,
    input  in_ready, input_load_en, X_shift, mac_en, mac_clr,
    input  elem_idx, pass_idx, col_done, busy, done
  );

  // Sequencer side.
  modport slave (
`ifdef XBUF_CTRL_STALL_CNT_EN
    output stall_cnt,
`endif
    input  start, in_valid, w_valid,
    output in_ready, input_load_en, X_shift, mac_en, mac_clr,
    output elem_idx, pass_idx, col_done, busy, done
  );
endinterface

// File: rtl/x_buffer_ctrl.sv
// Sequencer for the 4-lane X operand buffer: fills it from the byte stream,
// then replays it N_PASS times by rotation, stalling on coefficient availability.
// Optional feature macro: XBUF_CTRL_STALL_CNT_EN (RUN stall-cycle counter).
module x_buffer_ctrl #(
  parameter int unsigned N_LANE = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned N_PASS = 4,
  parameter int unsigned PASS_W = 2
) (
  input logic      clk,
  input logic      rst,
  x_buffer_if.slave bus
);
  localparam int unsigned ELEM_W = $clog2(DEPTH);
  localparam int unsigned FILL   = N_LANE * DEPTH;
  localparam int unsigned LOAD_W = $clog2(FILL);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [LOAD_W-1:0] load_cnt, load_cnt_nxt;
  logic [ELEM_W-1:0] elem, elem_nxt;
  logic [PASS_W-1:0] pass, pass_nxt;

  logic last_beat, last_elem, last_pass;

  assign last_beat = (load_cnt == LOAD_W'(FILL - 1));
  assign last_elem = (elem == ELEM_W'(DEPTH - 1));
  assign last_pass = (pass == PASS_W'(N_PASS - 1));

  assign bus.elem_idx = elem;
  assign bus.pass_idx = pass;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      elem     <= '0;
      pass     <= '0;
    end else begin
      state    <= state_nxt;
      load_cnt <= load_cnt_nxt;
      elem     <= elem_nxt;
      pass     <= pass_nxt;
    end
  end

  // Next-state, counter updates and strobes.
  always_comb begin
    state_nxt         = state;
    load_cnt_nxt      = load_cnt;
    elem_nxt          = elem;
    pass_nxt          = pass;
    bus.in_ready      = 1'b0;
    bus.input_load_en = 1'b0;
    bus.X_shift       = 1'b0;
    bus.mac_en        = 1'b0;
    bus.mac_clr       = 1'b0;
    bus.col_done      = 1'b0;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt   = S_LOAD;
          bus.mac_clr = 1'b1;
        end
      end
      S_LOAD: begin
        bus.busy          = 1'b1;
        bus.in_ready      = 1'b1;
        bus.input_load_en = bus.in_valid;
        if (bus.in_valid) begin
          if (last_beat) begin
            load_cnt_nxt = '0;
            state_nxt    = S_RUN;
          end else begin
            load_cnt_nxt = load_cnt + LOAD_W'(1);
          end
        end
      end
      S_RUN: begin
        bus.busy    = 1'b1;
        bus.X_shift = bus.w_valid;
        bus.mac_en  = bus.w_valid;
        if (bus.w_valid) begin
          elem_nxt = last_elem ? '0 : elem + ELEM_W'(1);
          if (last_elem) begin
            bus.col_done = 1'b1;
            if (last_pass) begin
              pass_nxt  = '0;
              state_nxt = S_DONE;
            end else begin
              pass_nxt    = pass + PASS_W'(1);
              bus.mac_clr = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef XBUF_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
  assign bus.stall_cnt = stall_cnt;

  // Saturating count of RUN cycles lost to missing coefficients.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && bus.start) begin
      stall_cnt <= '0;
    end else if (state == S_RUN && !bus.w_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_x_buffer_ctrl.sv
// Self-checking bench for x_buffer_ctrl with a byte-level model of the X buffer
// and a scoreboard of expected per-element lane bytes and strobes.
`timescale 1ns/1ps
module tb_x_buffer_ctrl;
  localparam int unsigned N_LANE = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned N_PASS = 4;
  localparam int unsigned FILL   = N_LANE * DEPTH;

  typedef struct packed {
    logic [1:0]  pass;
    logic [2:0]  elem;
    logic [31:0] lanes;
    logic        col_done;
    logic        mac_clr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  always #5 clk = ~clk;

  x_buffer_if #(.ELEM_W(3), .PASS_W(2)) bus ();
  x_buffer_if #(.ELEM_W(3), .PASS_W(1)) bus1 ();

  x_buffer_ctrl #(.N_LANE(N_LANE), .DEPTH(DEPTH), .N_PASS(N_PASS), .PASS_W(2))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Single-pass build driven by the same stimulus.
  x_buffer_ctrl #(.N_LANE(N_LANE), .DEPTH(DEPTH), .N_PASS(1), .PASS_W(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.start    = bus.start;
  assign bus1.in_valid = bus.in_valid;
  assign bus1.w_valid  = bus.w_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t sb[$];
  exp_t mon_x;

  int first_mac, done_cyc, done_cnt;
  int col1_cnt, clr1_cnt, done1_cnt, col1_cyc, done1_cyc;
  int op_start;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input int k, input logic [7:0] seed);
    return 8'(k) ^ seed;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // X buffer model: round-robin fill into lane LSB, byte rotation toward MSB.
  logic [63:0] xbuf [4];
  logic [1:0]  fill;
  always @(posedge clk) begin
    if (!rst) begin
      fill <= 2'd0;
    end else if (bus.input_load_en) begin
      xbuf[fill] <= {xbuf[fill][55:0], in_data};
      fill <= fill + 2'd1;
    end else if (bus.X_shift) begin
      for (int l = 0; l < 4; l++) xbuf[l] <= {xbuf[l][55:0], xbuf[l][63:56]};
    end
  end

  // Expected MAC stream for one operation.
  task automatic push_expect(input logic [7:0] seed);
    exp_t x;
    for (int p = 0; p < int'(N_PASS); p++) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        x.pass = 2'(p);
        x.elem = 3'(e);
        for (int l = 0; l < 4; l++) x.lanes[8*l +: 8] = byte_of(l + 4*e, seed);
        x.col_done = (e == int'(DEPTH) - 1);
        x.mac_clr  = (e == int'(DEPTH) - 1) && (p != int'(N_PASS) - 1);
        sb.push_back(x);
      end
    end
  endtask

  // Per-cycle monitor: scoreboard pop on mac_en plus strobe invariants.
  always @(negedge clk) begin
    if (rst) begin
      check("shift_vs_mac", 64'(bus.X_shift), 64'(bus.mac_en));
      check("load_shift_excl", 64'(bus.X_shift & bus.input_load_en), 64'd0);
      if (bus.mac_en) begin
        if (first_mac < 0) first_mac = cyc;
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          mon_x = sb.pop_front();
          check("elem_idx", 64'(bus.elem_idx), 64'(mon_x.elem));
          check("pass_idx", 64'(bus.pass_idx), 64'(mon_x.pass));
          check("lane_msb", 64'({xbuf[3][63:56], xbuf[2][63:56], xbuf[1][63:56], xbuf[0][63:56]}),
                64'(mon_x.lanes));
          check("col_done", 64'(bus.col_done), 64'(mon_x.col_done));
          check("run_mac_clr", 64'(bus.mac_clr), 64'(mon_x.mac_clr));
        end
      end else begin
        check("col_done_no_mac", 64'(bus.col_done), 64'd0);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus1.col_done) begin
        col1_cnt++;
        col1_cyc = cyc;
      end
      if (bus1.mac_clr) clr1_cnt++;
      if (bus1.done) begin
        done1_cnt++;
        done1_cyc = cyc;
      end
    end
  end

  // One full operation; stall_n cycles of w_valid=0 at elem 5 of pass 2.
  task automatic run_op(input logic [7:0] seed, input bit toggle, input int stall_n,
                        input bit start_run, input bit start_done);
    int k, guard, last_beat, exp_first, exp_done, stall_left;
    done_cnt = 0; first_mac = -1; done_cyc = -1;
    col1_cnt = 0; clr1_cnt = 0; done1_cnt = 0; col1_cyc = -1; done1_cyc = -1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    push_expect(seed);
    @(negedge clk);
    op_start = cyc;
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("start_mac_clr", 64'(bus.mac_clr), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0; guard = 0; last_beat = -1;
    while (k < int'(FILL) && guard < 4 * int'(FILL)) begin
      bus.in_valid = toggle ? (guard % 2 == 0) : 1'b1;
      in_data = byte_of(k, seed);
      @(negedge clk);
      check("load_ready", 64'(bus.in_ready), 64'd1);
      check("load_en", 64'(bus.input_load_en), 64'(bus.in_valid));
      check("load_no_mac", 64'(bus.mac_en), 64'd0);
      if (bus.in_valid) begin
        k++;
        if (k == int'(FILL)) last_beat = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (k != int'(FILL)) check("load_timeout", 64'(k), 64'(FILL));
    exp_first  = last_beat + 1;
    exp_done   = exp_first + int'(DEPTH * N_PASS) + stall_n;
    stall_left = stall_n;
    guard = 0;
    while (done_cyc < 0 && guard < 200) begin
      bus.w_valid = 1'b1;
      if (stall_left > 0 && bus.pass_idx == 2'd2 && bus.elem_idx == 3'd5) begin
        bus.w_valid = 1'b0;
        stall_left--;
      end
      bus.start = (start_run && cyc == exp_first + 10) || (start_done && cyc == exp_done);
      @(negedge clk);
      if (!bus.w_valid) begin
        check("stall_no_mac", 64'(bus.mac_en), 64'd0);
        check("stall_elem", 64'(bus.elem_idx), 64'd5);
        check("stall_pass", 64'(bus.pass_idx), 64'd2);
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.start = 1'b0;
    bus.w_valid = 1'b0;
    check("first_mac_cyc", 64'(first_mac), 64'(exp_first));
    if (!toggle) check("start_to_mac", 64'(first_mac - op_start), 64'(1 + FILL));
    check("done_cyc", 64'(done_cyc), 64'(exp_done));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_idle_busy", 64'(bus.busy), 64'd0);
    end
    check("done_count", 64'(done_cnt), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
`ifdef XBUF_CTRL_STALL_CNT_EN
    check("stall_cnt", 64'(bus.stall_cnt), 64'(stall_n));
`endif
  endtask

  // Abort a fill after 10 beats with reset.
  task automatic reset_mid_load();
    done_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_ready", 64'(bus.in_ready), 64'd0);
    check("abort_idx", 64'({bus.pass_idx, bus.elem_idx}), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.w_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_strobes", 64'({bus.in_ready, bus.input_load_en, bus.X_shift, bus.mac_en,
                              bus.mac_clr, bus.col_done, bus.done}), 64'd0);
    check("rst_idx", 64'({bus.pass_idx, bus.elem_idx}), 64'd0);
`ifdef XBUF_CTRL_STALL_CNT_EN
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
`endif

    // Bytes 0x00..0x1F, no stalls; single-pass build observed alongside.
    run_op(8'h00, 1'b0, 0, 1'b0, 1'b0);
    check("np1_col_done", 64'(col1_cnt), 64'd1);
    check("np1_mac_clr", 64'(clr1_cnt), 64'd1);
    check("np1_done", 64'(done1_cnt), 64'd1);
    check("np1_col_cyc", 64'(col1_cyc), 64'(op_start + 1 + int'(FILL) + int'(DEPTH) - 1));
    check("np1_done_cyc", 64'(done1_cyc), 64'(col1_cyc + 1));

    reset_mid_load();
    run_op(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    run_op(8'h3C, 1'b0, 3, 1'b0, 1'b0);
    run_op(8'h5A, 1'b0, 0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
